// File: rtl/lpc_host.sv
// LPC host initiator: turns one request into a full LPC IO (or memory) cycle on LAD/LFRAME#.
// Memory cycles are only supported when LPC_HOST_MEM_EN is defined.
module lpc_host #(
    parameter int SYNC_TIMEOUT = 8,
    parameter int ABORT_CYCLES = 4
) (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cyctype_dir,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_data,
    output logic        resp_valid,
    output logic [7:0]  resp_data,
    output logic [1:0]  resp_status,
    output logic        lpc_frame,
    output logic [3:0]  lpc_ad_out,
    output logic        lpc_ad_oe,
    input  logic [3:0]  lpc_ad_in
);
`ifdef LPC_HOST_MEM_EN
    localparam int ADDR_W = 32;
`else
    localparam int ADDR_W = 16;
`endif
    localparam logic [7:0] SYNC_LIM   = 8'(SYNC_TIMEOUT);
    localparam logic [7:0] ABORT_LAST = 8'(ABORT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, START, CTDIR, ADDR, WDATA, TAR_H1, TAR_H2,
        SYNC, RDATA, TAR_P1, TAR_P2, ABORT, DONE
    } state_t;

    state_t            state, next;
    logic [ADDR_W-1:0] addr_sh;
    logic [7:0]        wdata_sh;
    logic [7:0]        rdata;
    logic [2:0]        ctdir;
    logic              is_wr, is_mem;
    logic [7:0]        cnt, sync_cnt;
    logic [1:0]        st;
    logic              accept, unsupported;
    logic              unused_bits;

    assign accept      = req_valid & req_ready;
    assign unused_bits = ^{req_cyctype_dir[0], req_addr[31:16]};
`ifdef LPC_HOST_MEM_EN
    assign unsupported = req_cyctype_dir[3];
`else
    assign unsupported = req_cyctype_dir[3] | req_cyctype_dir[2];
`endif

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) state <= IDLE;
        else            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:   if (req_valid) next = unsupported ? DONE : START;
            START:  next = CTDIR;
            CTDIR:  next = ADDR;
            ADDR:   if (cnt == (is_mem ? 8'd7 : 8'd3)) next = is_wr ? WDATA : TAR_H1;
            WDATA:  if (cnt == 8'd1) next = TAR_H1;
            TAR_H1: next = TAR_H2;
            TAR_H2: next = SYNC;
            SYNC: begin
                case (lpc_ad_in)
                    4'b0000, 4'b1010: next = is_wr ? TAR_P1 : RDATA;
                    4'b0101:          if (sync_cnt + 8'd1 == SYNC_LIM) next = ABORT;
                    4'b0110:          next = SYNC;
                    default:          next = ABORT;
                endcase
            end
            RDATA:  if (cnt == 8'd1) next = TAR_P1;
            TAR_P1: next = TAR_P2;
            TAR_P2: next = DONE;
            ABORT:  if (cnt == ABORT_LAST) next = DONE;
            DONE:   next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        lpc_frame  = 1'b1;
        lpc_ad_out = 4'hf;
        lpc_ad_oe  = 1'b0;
        case (state)
            IDLE:   req_ready = 1'b1;
            START:  begin lpc_frame = 1'b0; lpc_ad_out = 4'h0; lpc_ad_oe = 1'b1; end
            CTDIR:  begin lpc_ad_out = {ctdir, 1'b0}; lpc_ad_oe = 1'b1; end
            ADDR:   begin lpc_ad_out = addr_sh[ADDR_W-1 -: 4]; lpc_ad_oe = 1'b1; end
            WDATA:  begin lpc_ad_out = wdata_sh[3:0]; lpc_ad_oe = 1'b1; end
            TAR_H1: lpc_ad_oe = 1'b1;
            ABORT:  begin lpc_frame = 1'b0; lpc_ad_oe = 1'b1; end
            DONE:   resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Control and response state; resp_* load as DONE is entered so they line up with resp_valid
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            ctdir       <= 3'b0;
            is_wr       <= 1'b0;
            is_mem      <= 1'b0;
            cnt         <= 8'd0;
            sync_cnt    <= 8'd0;
            st          <= 2'b00;
            resp_data   <= 8'h00;
            resp_status <= 2'b00;
        end else begin
            if (accept) begin
                ctdir    <= req_cyctype_dir[3:1];
                is_wr    <= req_cyctype_dir[1];
                is_mem   <= req_cyctype_dir[2];
                cnt      <= 8'd0;
                sync_cnt <= 8'd0;
                st       <= unsupported ? 2'b11 : 2'b00;
            end else begin
                cnt <= (state != next) ? 8'd0 : cnt + 8'd1;
                if (state == SYNC) begin
                    case (lpc_ad_in)
                        4'b0000: ;
                        4'b0101: begin
                            sync_cnt <= sync_cnt + 8'd1;
                            if (sync_cnt + 8'd1 == SYNC_LIM) st <= 2'b10;
                        end
                        4'b0110: sync_cnt <= 8'd0;
                        default: st <= 2'b01;
                    endcase
                end
            end
            if (next == DONE && state != DONE) begin
                if (state == IDLE) begin
                    resp_data   <= 8'h00;
                    resp_status <= 2'b11;
                end else begin
                    resp_data   <= rdata;
                    resp_status <= st;
                end
            end
        end
    end

    // Datapath shift registers; rdata cleared at acceptance so writes and aborts report 0
    always_ff @(posedge lpc_clock) begin
        if (accept) begin
`ifdef LPC_HOST_MEM_EN
            addr_sh <= req_cyctype_dir[2] ? req_addr : {req_addr[15:0], 16'h0000};
`else
            addr_sh <= req_addr[15:0];
`endif
            wdata_sh <= req_data;
            rdata    <= 8'h00;
        end else begin
            if (state == ADDR)  addr_sh  <= {addr_sh[ADDR_W-5:0], 4'h0};
            if (state == WDATA) wdata_sh <= {4'h0, wdata_sh[7:4]};
            if (state == RDATA) begin
                if (cnt == 8'd0) rdata[3:0] <= lpc_ad_in;
                else             rdata[7:4] <= lpc_ad_in;
            end
        end
    end
endmodule

// File: tb/tb_lpc_host.sv
// Directed bench for lpc_host: a scripted peripheral answers SYNC/data nibbles after the host turnaround.
// Memory-cycle expectations follow LPC_HOST_MEM_EN.
module tb_lpc_host;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cyctype_dir;
    logic [31:0] req_addr;
    logic [7:0]  req_data;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic [1:0]  resp_status;
    logic        lpc_frame;
    logic [3:0]  lpc_ad_out;
    logic        lpc_ad_oe;
    logic [3:0]  lpc_ad_in;

    int checks = 0;
    int passed = 0;

    logic [3:0]  sq [0:15];
    int          sq_len;
    int          r_lat, r_nib, r_flow, r_busy;
    logic [63:0] r_log;
    logic [7:0]  r_data;
    logic [1:0]  r_status;

    lpc_host #(.SYNC_TIMEOUT(8), .ABORT_CYCLES(4)) dut (
        .lpc_clock(clk), .lpc_reset(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cyctype_dir(req_cyctype_dir), .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_status(resp_status),
        .lpc_frame(lpc_frame), .lpc_ad_out(lpc_ad_out), .lpc_ad_oe(lpc_ad_oe),
        .lpc_ad_in(lpc_ad_in)
    );

    always #5 clk = ~clk;

    task automatic load_seq(input logic [63:0] s, input int len);
        for (int i = 0; i < len; i++) sq[i] = s[(len-1-i)*4 +: 4];
        sq_len = len;
    endtask

    // Issue one request, play the peripheral script from the first SYNC cycle, record the bus.
    task automatic run(input logic [3:0] ct, input logic [31:0] a, input logic [7:0] d);
        logic prev_oe;
        bit   armed;
        int   p;
        r_log = 64'h0; r_nib = 0; r_flow = 0; r_busy = 0; r_lat = -1;
        r_data = 8'hxx; r_status = 2'bxx;
        @(negedge clk);
        for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
        req_cyctype_dir = ct; req_addr = a; req_data = d; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        prev_oe = 1'b0; armed = 1'b0; p = 0;
        for (int n = 0; n < 200; n++) begin
            if (lpc_ad_oe) begin r_log = {r_log[59:0], lpc_ad_out}; r_nib++; end
            if (!lpc_frame) r_flow++;
            if (req_ready) r_busy++;
            if (resp_valid) begin
                r_lat = n; r_data = resp_data; r_status = resp_status;
                break;
            end
            if (armed) begin
                lpc_ad_in = (p < sq_len) ? sq[p] : 4'hf;
                p++;
            end else if (prev_oe && !lpc_ad_oe) begin
                armed = 1'b1;
            end
            prev_oe = lpc_ad_oe;
            @(posedge clk); #1;
        end
        lpc_ad_in = 4'hf;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (lpc_frame !== 1'b1) $display("FAIL rst_frame: got %b want 1", lpc_frame); else passed++;
        checks++; if (lpc_ad_oe !== 1'b0) $display("FAIL rst_oe: got %b want 0", lpc_ad_oe); else passed++;
        checks++; if (lpc_ad_out !== 4'hf) $display("FAIL rst_ad: got %h want f", lpc_ad_out); else passed++;
        checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", req_ready); else passed++;
        checks++; if (resp_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", resp_valid); else passed++;
        checks++; if (resp_data !== 8'h00) $display("FAIL rst_data: got %h want 00", resp_data); else passed++;
        checks++; if (resp_status !== 2'b00) $display("FAIL rst_status: got %b want 00", resp_status); else passed++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_io_read();
        load_seq(64'h0c6, 3);
        run(4'b0000, 32'h0000_7fe5, 8'h00);
        checks++; if (r_lat !== 13) $display("FAIL io_rd_lat: got %0d want 13", r_lat); else passed++;
        checks++; if (r_data !== 8'h6c) $display("FAIL io_rd_data: got %h want 6c", r_data); else passed++;
        checks++; if (r_status !== 2'b00) $display("FAIL io_rd_status: got %b want 00", r_status); else passed++;
        checks++; if (r_log !== 64'h007fe5f || r_nib !== 7)
            $display("FAIL io_rd_lad: got %h/%0d want 007fe5f/7", r_log, r_nib); else passed++;
        checks++; if (r_flow !== 1) $display("FAIL io_rd_frame: got %0d want 1", r_flow); else passed++;
        checks++; if (r_busy !== 0) $display("FAIL io_rd_busy_ready: got %0d want 0", r_busy); else passed++;
    endtask

    task automatic test_io_write();
        load_seq(64'h0, 1);
        run(4'b0010, 32'h0000_0080, 8'ha5);
        checks++; if (r_lat !== 13) $display("FAIL io_wr_lat: got %0d want 13", r_lat); else passed++;
        checks++; if (r_data !== 8'h00) $display("FAIL io_wr_data: got %h want 00", r_data); else passed++;
        checks++; if (r_status !== 2'b00) $display("FAIL io_wr_status: got %b want 00", r_status); else passed++;
        checks++; if (r_log !== 64'h0200805af || r_nib !== 9)
            $display("FAIL io_wr_lad: got %h/%0d want 0200805af/9", r_log, r_nib); else passed++;
    endtask

    task automatic test_long_wait();
        load_seq(64'h666021, 6);
        run(4'b0000, 32'h0000_0060, 8'h00);
        checks++; if (r_lat !== 16) $display("FAIL lwait_lat: got %0d want 16", r_lat); else passed++;
        checks++; if (r_data !== 8'h12) $display("FAIL lwait_data: got %h want 12", r_data); else passed++;
        checks++; if (r_status !== 2'b00) $display("FAIL lwait_status: got %b want 00", r_status); else passed++;
    endtask

    task automatic test_timeout();
        load_seq(64'h555555555, 9);
        run(4'b0000, 32'h0000_0000, 8'h00);
        checks++; if (r_lat !== 20) $display("FAIL tmo_lat: got %0d want 20", r_lat); else passed++;
        checks++; if (r_status !== 2'b10) $display("FAIL tmo_status: got %b want 10", r_status); else passed++;
        checks++; if (r_data !== 8'h00) $display("FAIL tmo_data: got %h want 00", r_data); else passed++;
        checks++; if (r_flow !== 5) $display("FAIL tmo_frame_low: got %0d want 5", r_flow); else passed++;
        checks++; if (r_log[15:0] !== 16'hffff) $display("FAIL tmo_abort_lad: got %h want ffff", r_log[15:0]); else passed++;
    endtask

    task automatic test_sync_error();
        load_seq(64'hAff, 3);
        run(4'b0000, 32'h0000_0100, 8'h00);
        checks++; if (r_lat !== 13) $display("FAIL serr_lat: got %0d want 13", r_lat); else passed++;
        checks++; if (r_data !== 8'hff) $display("FAIL serr_data: got %h want ff", r_data); else passed++;
        checks++; if (r_status !== 2'b01) $display("FAIL serr_status: got %b want 01", r_status); else passed++;
        load_seq(64'h3, 1);
        run(4'b0000, 32'h0000_0100, 8'h00);
        checks++; if (r_lat !== 13) $display("FAIL badsync_lat: got %0d want 13", r_lat); else passed++;
        checks++; if (r_status !== 2'b01) $display("FAIL badsync_status: got %b want 01", r_status); else passed++;
        checks++; if (r_flow !== 5) $display("FAIL badsync_frame_low: got %0d want 5", r_flow); else passed++;
    endtask

    task automatic test_mem();
        load_seq(64'h043, 3);
        run(4'b0100, 32'hffff_fff0, 8'h00);
`ifdef LPC_HOST_MEM_EN
        checks++; if (r_lat !== 17) $display("FAIL mem_lat: got %0d want 17", r_lat); else passed++;
        checks++; if (r_log !== 64'h04fffffff0f || r_nib !== 11)
            $display("FAIL mem_lad: got %h/%0d want 04fffffff0f/11", r_log, r_nib); else passed++;
        checks++; if (r_data !== 8'h34) $display("FAIL mem_data: got %h want 34", r_data); else passed++;
        checks++; if (r_status !== 2'b00) $display("FAIL mem_status: got %b want 00", r_status); else passed++;
`else
        checks++; if (r_lat !== 0) $display("FAIL mem_lat: got %0d want 0", r_lat); else passed++;
        checks++; if (r_nib !== 0 || r_flow !== 0)
            $display("FAIL mem_bus: got %0d/%0d want 0/0", r_nib, r_flow); else passed++;
        checks++; if (r_status !== 2'b11) $display("FAIL mem_status: got %b want 11", r_status); else passed++;
`endif
        load_seq(64'h0, 1);
        run(4'b1000, 32'h0000_1234, 8'h00);
        checks++; if (r_lat !== 0 || r_nib !== 0 || r_flow !== 0)
            $display("FAIL unsup_bus: got %0d/%0d/%0d want 0/0/0", r_lat, r_nib, r_flow); else passed++;
        checks++; if (r_status !== 2'b11) $display("FAIL unsup_status: got %b want 11", r_status); else passed++;
        checks++; if (r_data !== 8'h00) $display("FAIL unsup_data: got %h want 00", r_data); else passed++;
    endtask

    task automatic test_back_to_back();
        load_seq(64'h0, 1);
        run(4'b0010, 32'h0000_0040, 8'h3c);
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", req_ready); else passed++;
        load_seq(64'h09a, 3);
        run(4'b0000, 32'h0000_0041, 8'h00);
        checks++; if (r_lat !== 13 || r_data !== 8'ha9)
            $display("FAIL b2b_read: got %0d/%h want 13/a9", r_lat, r_data); else passed++;
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        req_cyctype_dir = 4'b0000; req_addr = 32'h0000_1234; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b0; #1;
        checks++; if (lpc_frame !== 1'b1 || lpc_ad_oe !== 1'b0)
            $display("FAIL rmid_bus: got %b/%b want 1/0", lpc_frame, lpc_ad_oe); else passed++;
        checks++; if (req_ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", req_ready); else passed++;
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL rmid_resp: got %0d want 0", seen); else passed++;
        load_seq(64'h078, 3);
        run(4'b0000, 32'h0000_0002, 8'h00);
        checks++; if (r_lat !== 13 || r_data !== 8'h87)
            $display("FAIL rmid_recover: got %0d/%h want 13/87", r_lat, r_data); else passed++;
    endtask

    initial begin
        req_valid = 1'b0; req_cyctype_dir = 4'h0; req_addr = 32'h0; req_data = 8'h0;
        lpc_ad_in = 4'hf; sq_len = 0;
        test_reset();
        test_io_read();
        test_io_write();
        test_long_wait();
        test_timeout();
        test_sync_error();
        test_mem();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
